prbs_checker: RTL



---
 rtl/prbs_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
// Define PRBS_CHECK_BITERR_EN to count errored bits instead of errored words.
module prbs_checker #(
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 3,
   parameter int ERR_W  = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [7:0]       I,
   input  logic             VALID,
   input  logic             CLR,
   output logic             LOCKED,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT
);

   typedef enum logic {
      SEARCH,
      LOCK
   } state_t;

   localparam int SW = ERR_W + 4;
   localparam logic [3:0] LOCK_M1 = 4'(LOCK_N - 1);
   localparam logic [3:0] LOSS_M1 = 4'(LOSS_N - 1);
   localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

   state_t           state_q, state_d;
   logic [7:0]       ref_word, ref_d;
   logic             ref_vld, vld_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       bad_q, bad_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic [7:0]  exp_word;
   logic        match;
   logic [3:0]  inc;
   logic [SW-1:0] sum;

   assign exp_word = {ref_word[6:0],
                      ref_word[7] ^ ref_word[5] ^ ref_word[4] ^ ref_word[3]};
   // All-zero is the lock-up state and is never a valid word.
   assign match = ref_vld && (I == exp_word) && (I != 8'h00);

`ifdef PRBS_CHECK_BITERR_EN
   logic [7:0] diff;
   assign diff = I ^ exp_word;
   always_comb begin
      inc = 4'd0;
      for (int k = 0; k < 8; k++) begin
         inc = inc + 4'(diff[k]);
      end
   end
`else
   assign inc = 4'd1;
`endif

   assign sum = SW'(cnt_q) + SW'(inc);

   always_comb begin
      state_d = state_q;
      ref_d   = ref_word;
      vld_d   = ref_vld;
      run_d   = run_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      if (VALID) begin
         unique case (state_q)
            SEARCH: begin
               ref_d = I;
               vld_d = 1'b1;
               run_d = match ? run_q + 4'd1 : 4'd0;
               if (match && run_q == LOCK_M1) begin
                  state_d = LOCK;
                  bad_d   = 4'd0;
               end
            end
            LOCK: begin
               // Local copy free-runs so one bad word is one error.
               ref_d = exp_word;
               if (match) begin
                  bad_d = 4'd0;
               end else begin
                  err_d = 1'b1;
                  bad_d = bad_q + 4'd1;
                  if (bad_q == LOSS_M1) begin
                     state_d = SEARCH;
                     run_d   = 4'd0;
                     ref_d   = I;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (err_d) begin
         if (sum[SW-1:ERR_W] != '0) begin
            cnt_d = CNT_MAX;
         end else begin
            cnt_d = sum[ERR_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= SEARCH;
         ref_word <= 8'h00;
         ref_vld  <= 1'b0;
         run_q    <= 4'd0;
         bad_q    <= 4'd0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ref_word <= ref_d;
         ref_vld  <= vld_d;
         run_q    <= run_d;
         bad_q    <= bad_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign LOCKED  = (state_q == LOCK);
   assign ERR     = err_q;
   assign ERR_CNT = cnt_q;

endmodule
